lsm_sequencer: RTL
==================

Name: lsm_sequencer

Overview:
- Parametrised successor to the combinational load/store-multiple check logic.
- Owns the full LDM/STM transfer sequence: latches the register list, skips unset bits with a priority encoder (one transfer per accepted cycle), and generates register index, memory address and writeback base for all four addressing modes.
- Sits between the instruction decoder (IR fields, base value) and the control unit / memory interface, which consumes one transfer per VALID/NEXT handshake.

Parameters:
NREGS, 16, number of register-list bits / architectural registers
RW, 4, width of register index; must satisfy 2^RW >= NREGS
AW, 32, address width
WSTEP, 4, byte increment per transferred word

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  begin a sequence; sampled only in IDLE
IR_23  input  1  U bit: 1 = increment (up), 0 = decrement (down)
IR_24  input  1  P bit: 1 = pre-index (before), 0 = post-index (after)
REG_LIST  input  NREGS  register list, bit i = register i
BASE_ADDR  input  AW  base register value
NEXT  input  1  consumer accepts current transfer
BUSY  output  1  sequence in progress (SETUP, XFER, DONE)
VALID  output  1  REG_ADDR/MEM_ADDR hold a valid transfer
REG_ADDR  output  RW  register index of current transfer
MEM_ADDR  output  AW  word address of current transfer
LAST  output  1  current transfer is the final one
DONE  output  1  one-cycle pulse at sequence end
WB_ADDR  output  AW  writeback base value; valid from DONE until next START
XFER_COUNT  output  RW+1  number of set bits in latched list

Behaviour:
- Reset, or RESET asserted at any time including mid-sequence: next edge enters IDLE. All outputs are 0, the working list is cleared, and any in-flight sequence is abandoned with no DONE.
- States are IDLE, SETUP, XFER and DONE_ST.
- IDLE: when START=1, latch REG_LIST, IR_23, IR_24 and BASE_ADDR, then go to SETUP. START in any other state is ignored.
- SETUP (1 cycle, BUSY=1, VALID=0):
  - n = popcount(list), registered into XFER_COUNT.
  - Start address (all arithmetic modulo 2^AW):
    - IA (U=1,P=0): base
    - IB (U=1,P=1): base+WSTEP
    - DA (U=0,P=0): base-WSTEP*n+WSTEP
    - DB (U=0,P=1): base-WSTEP*n
  - WB_ADDR = base+WSTEP*n when U=1, base-WSTEP*n when U=0.
  - If n>0, go to XFER. If n==0, see Optional Feature.
- XFER:
  - VALID=1.
  - REG_ADDR = index of lowest set bit in the working list. Registers are always transferred in ascending order, lowest register at lowest address, for every mode.
  - LAST=1 when exactly one bit remains.
  - Outputs stay stable while NEXT=0.
  - On an edge with VALID&NEXT: clear that bit and MEM_ADDR += WSTEP. If LAST was 1, go to DONE_ST (VALID drops the same edge).
  - First VALID appears 2 cycles after the START edge. Back-to-back NEXT=1 gives one transfer per cycle.
- DONE_ST (1 cycle): DONE=1, BUSY=1, VALID=0, then go to IDLE. WB_ADDR and XFER_COUNT hold their values until the next START is accepted.
- START held high through DONE_ST is ignored; it is accepted in the following IDLE cycle.

Optional Feature:
- Macro: LSM_EMPTY_LIST_EN.
- Defined (ARMv4 empty-list semantics): n==0 is treated as a list containing only register NREGS-1 (R15). The sequence makes a single transfer with REG_ADDR=NREGS-1 and LAST=1. Start address is computed with n=1. WB_ADDR = base ± WSTEP*NREGS (e.g. ±0x40). XFER_COUNT=0.
- Undefined: n==0 goes SETUP -> DONE_ST directly, with no VALID, DONE pulse 2 cycles after START, WB_ADDR=base and XFER_COUNT=0.

Test Plan:
- IA, list 0x8011, base 0x1000, NEXT=1: REG_ADDR 0,4,15 at MEM_ADDR 0x1000,0x1004,0x1008. LAST on 15, DONE next cycle, WB_ADDR 0x100C, XFER_COUNT 3.
- DB, list 0x000E, base 0x2000: REG_ADDR 1,2,3 at 0x1FF4,0x1FF8,0x1FFC. WB_ADDR 0x1FF4.
- IB with NEXT toggling 1,0,0,1 on list 0x0003, base 0x0: REG_ADDR/MEM_ADDR hold (0,0x4) during stalls. Then (1,0x8), DONE, WB_ADDR 0x8.
- DA, list 0xFFFF, base 0x0000_0010: 16 transfers starting at MEM_ADDR 0xFFFF_FFD4, wrapping through 0x0. WB_ADDR 0xFFFF_FFD0. START pulses mid-sequence are ignored.
- RESET asserted on 2nd transfer of list 0x00F0: next cycle all outputs 0, no DONE. A new START with list 0x0001 then runs normally.
- List 0x0000, base 0x100, U=1: without macro, DONE 2 cycles after START, no VALID, WB_ADDR 0x100. With LSM_EMPTY_LIST_EN, one transfer REG_ADDR 15 at 0x100, WB_ADDR 0x140.

Source files
------------

// File: rtl/lsm_sequencer.sv
// LDM/STM transfer sequencer: list latch, priority skip, address/writeback gen.
// Optional LSM_EMPTY_LIST_EN: empty list transfers only register NREGS-1.
module lsm_sequencer #(
  parameter int NREGS = 16,
  parameter int RW    = 4,
  parameter int AW    = 32,
  parameter int WSTEP = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_ir_23,
  input  logic             i_ir_24,
  input  logic [NREGS-1:0] i_reg_list,
  input  logic [AW-1:0]    i_base_addr,
  input  logic             i_next,
  output logic             o_busy,
  output logic             o_valid,
  output logic [RW-1:0]    o_reg_addr,
  output logic [AW-1:0]    o_mem_addr,
  output logic             o_last,
  output logic             o_done,
  output logic [AW-1:0]    o_wb_addr,
  output logic [RW:0]      o_xfer_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_DONE
  } state_t;

  localparam logic [NREGS-1:0] ONE  = 1;
  localparam logic [AW-1:0]    STEP = AW'(WSTEP);

  state_t           r_state;
  state_t           w_next_state;
  logic [NREGS-1:0] r_list;
  logic             r_u;
  logic             r_p;
  logic [AW-1:0]    r_base;
  logic [AW-1:0]    r_mem;
  logic [AW-1:0]    r_wb;
  logic [RW:0]      r_count;

  logic [RW:0]      w_cnt;
  logic [RW-1:0]    w_idx;
  logic [NREGS-1:0] w_list_m1;
  logic             w_one_left;
  logic [AW-1:0]    w_na;
  logic [AW-1:0]    w_nw;
  logic [AW-1:0]    w_span_a;
  logic [AW-1:0]    w_span_w;
  logic [AW-1:0]    w_start;
  logic [AW-1:0]    w_wb;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NREGS; i++)
      w_cnt = w_cnt + (RW+1)'(r_list[i]);
  end

  // Scan downward so the lowest set bit wins.
  always_comb begin
    w_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--)
      if (r_list[i]) w_idx = RW'(i);
  end

  assign w_list_m1  = r_list - ONE;
  assign w_one_left = (r_list != '0) &&
                      ((r_list & w_list_m1) == '0);

`ifdef LSM_EMPTY_LIST_EN
  localparam logic [NREGS-1:0] TOPBIT = ONE << (NREGS - 1);
  logic w_empty;
  assign w_empty = (w_cnt == '0);
  assign w_na = w_empty ? AW'(1) : AW'(w_cnt);
  assign w_nw = w_empty ? AW'(NREGS) : AW'(w_cnt);
`else
  assign w_na = AW'(w_cnt);
  assign w_nw = AW'(w_cnt);
`endif

  assign w_span_a = STEP * w_na;
  assign w_span_w = STEP * w_nw;

  always_comb begin
    w_start = r_base;
    unique case (1'b1)
      ( r_u && !r_p): w_start = r_base;
      ( r_u &&  r_p): w_start = r_base + STEP;
      (!r_u && !r_p): w_start = r_base - w_span_a + STEP;
      (!r_u &&  r_p): w_start = r_base - w_span_a;
      default:        w_start = r_base;
    endcase
  end

  assign w_wb = r_u ? r_base + w_span_w
                    : r_base - w_span_w;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:
        if (i_start) w_next_state = S_SETUP;
      S_SETUP: begin
`ifdef LSM_EMPTY_LIST_EN
        w_next_state = S_XFER;
`else
        if (w_cnt != '0) w_next_state = S_XFER;
        else             w_next_state = S_DONE;
`endif
      end
      S_XFER:
        if (i_next && w_one_left) w_next_state = S_DONE;
      S_DONE:
        w_next_state = S_IDLE;
      default:
        w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_list  <= '0;
      r_u     <= 1'b0;
      r_p     <= 1'b0;
      r_base  <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (i_start) begin
            r_list <= i_reg_list;
            r_u    <= i_ir_23;
            r_p    <= i_ir_24;
            r_base <= i_base_addr;
          end
        S_SETUP: begin
          r_count <= w_cnt;
          r_wb    <= w_wb;
          r_mem   <= w_start;
`ifdef LSM_EMPTY_LIST_EN
          if (w_empty) r_list <= TOPBIT;
`endif
        end
        S_XFER:
          if (i_next) begin
            r_list <= r_list & w_list_m1;
            r_mem  <= r_mem + STEP;
          end
        default: ;
      endcase
    end
  end

  assign o_busy       = (r_state != S_IDLE);
  assign o_valid      = (r_state == S_XFER);
  assign o_reg_addr   = o_valid ? w_idx : '0;
  assign o_mem_addr   = o_valid ? r_mem : '0;
  assign o_last       = o_valid && w_one_left;
  assign o_done       = (r_state == S_DONE);
  assign o_wb_addr    = r_wb;
  assign o_xfer_count = r_count;

endmodule
